// File: rtl/gcd_if.sv
// Operand/result handshake bundle for gcd_ctrl.
// The slave side belongs to the GCD engine; the master side drives operands and drains results.
interface gcd_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [15:0]      iter_count;
    logic             err;
    logic             busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, iter_count, err, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, iter_count, err, busy
    );
endinterface

// File: rtl/gcd_ctrl.sv
// Subtractive GCD engine with a step limit and valid/ready handshakes.
// One subtraction per cycle; zero operands short-circuit straight to the result.
module gcd_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 1024
) (
    input  logic  clk,
    input  logic  rst,
    gcd_if.slave  io
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [15:0] MAX_C = 16'(MAX_ITER);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [15:0]      iter_q, iter_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        iter_d  = iter_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    x_d   = io.a;
                    y_d   = io.b;
                    cnt_d = '0;
                    if (io.a == '0 || io.b == '0) begin
                        state_d = DONE;
                        res_d   = io.a | io.b;
                        iter_d  = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Equality wins over the limit so a pair finishing exactly at the limit succeeds
                if (x_q == y_q) begin
                    state_d = DONE;
                    res_d   = x_q;
                    iter_d  = cnt_q;
                    err_d   = 1'b0;
                end else if (cnt_q == MAX_C) begin
                    state_d = DONE;
                    res_d   = '0;
                    iter_d  = cnt_q;
                    err_d   = 1'b1;
                end else if (x_q > y_q) begin
                    x_d   = x_q - y_q;
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    y_d   = y_q - x_q;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign io.in_ready   = (state_q == IDLE);
    assign io.out_valid  = (state_q == DONE);
    assign io.busy       = (state_q == CALC);
    assign io.result     = res_q;
    assign io.iter_count = iter_q;
    assign io.err        = err_q;
endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl: Euclid-by-division reference model,
// directed corner cases plus randomized operand pairs.
module tb_gcd_ctrl;
    localparam int W   = 32;
    localparam int MAX = 16;

    typedef struct {
        logic [W-1:0] res;
        logic [15:0]  iter;
        logic         err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t held;
    bit   prev_v;

    gcd_if #(.WIDTH(W)) bus ();

    gcd_ctrl #(.WIDTH(W), .MAX_ITER(MAX)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steps of the subtractive algorithm = sum of Euclid quotients minus one.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint unsigned x, y, q, r, steps;
        if (a == 0 || b == 0) begin
            e.res  = a | b;
            e.iter = 16'd0;
            e.err  = 1'b0;
            return e;
        end
        x = a;
        y = b;
        steps = 0;
        while (y != 0) begin
            q = x / y;
            r = x % y;
            steps += q;
            x = y;
            y = r;
        end
        steps -= 1;
        if (steps > MAX) begin
            e.res  = '0;
            e.iter = 16'(MAX);
            e.err  = 1'b1;
        end else begin
            e.res  = W'(x);
            e.iter = 16'(steps);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: first cycle of each DONE pops the scoreboard, later cycles check stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got result %0d with empty scoreboard",
                                 bus.result);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("result", bus.result, e.res);
                        chk("iter_count", bus.iter_count, e.iter);
                        chk("err", bus.err, e.err);
                    end
                    held.res  = bus.result;
                    held.iter = bus.iter_count;
                    held.err  = bus.err;
                end else begin
                    chk("hold_result", bus.result, held.res);
                    chk("hold_iter", bus.iter_count, held.iter);
                    chk("hold_err", bus.err, held.err);
                end
            end
            prev_v = bus.out_valid;
        end
    end

    // Issue one pair from IDLE, with noisy in_valid while busy, stall, then hand off.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   j;
        int   busy_n;
        int   exp_lat;
        e = model(a, b);
        exp_lat = (a == 0 || b == 0) ? 0 : int'(e.iter) + 1;
        chk("in_ready_before", bus.in_ready, 1);
        sb.push_back(e);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        j = 0;
        busy_n = 0;
        while (!bus.out_valid && j < 3000) begin
            if (bus.busy) busy_n++;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk);
            #1;
            j++;
        end
        chk("latency", j, exp_lat);
        chk("busy_cycles", busy_n, exp_lat);
        if (!bus.out_valid) begin
            $display("FAIL timeout: no out_valid within bound");
            $fatal(1, "stuck");
        end
        repeat (hold) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after", bus.in_ready, 1);
        chk("out_valid_after", bus.out_valid, 0);
    endtask

    function automatic logic [W-1:0] rand_op(input int mode, input logic [W-1:0] g);
        unique case (mode)
            0: return W'($urandom_range(0, 40));
            1: return g * W'($urandom_range(1, 8));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        prev_v  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_iter", bus.iter_count, 0);
        chk("rst_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'd12, 32'd8, 0);
        do_op(32'd0, 32'd9, 1);
        do_op(32'd7, 32'd7, 0);
        do_op(32'd1, 32'd100, 2);
        do_op(32'd48, 32'd18, 5);
        do_op(32'd0, 32'd0, 0);

        // Abandon a calculation by resetting in its third CALC cycle.
        bus.in_valid = 1'b1;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_iter", bus.iter_count, 0);
        chk("mid_rst_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd21, 32'd14, 0);

        for (int i = 0; i < 40; i++) begin
            int           mode;
            logic [W-1:0] g;
            logic [W-1:0] x;
            mode = $urandom_range(0, 3);
            g = W'($urandom_range(1, 1 << 27));
            x = rand_op(mode, g);
            if (mode == 2) do_op(x, x, $urandom_range(0, 3));
            else do_op(x, rand_op(mode, g), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
